// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral.
// Holds counter limits, pin count, default prescaler, the per-pin drive mode
// and small elaboration-time helpers used by the top and the tick generator.
package pwm_pkg;

    localparam int unsigned DUTY_W          = 8;
    localparam int unsigned NUM_PINS        = 16;
    localparam int unsigned CLK_DIV_DEFAULT = 13;

    // Last value of the PWM counter; 255 is never reached, so duty 0xFF
    // keeps the waveform permanently high.
    localparam logic [DUTY_W-1:0] PWM_CNT_MAX = 8'd254;

    typedef enum logic [1:0] {
        PIN_LOW  = 2'd0,
        PIN_HIGH = 2'd1,
        PIN_PWM  = 2'd2
    } pin_mode_e;

    // Output enable dominates: a disabled pin is low whatever its PWM select.
    function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
        if (!en_out) begin
            return PIN_LOW;
        end
        return en_pwm ? PIN_PWM : PIN_HIGH;
    endfunction

    // Prescaler width; a divide-by-1 still needs a 1-bit register.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Clock prescaler for the PWM peripheral.
// Counts 0..CLK_DIV-1 and raises tick_o for the single clk cycle in which the
// count sits at CLK_DIV-1; the count wraps to 0 on that same cycle.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   tick_o  out one-cycle tick, once every CLK_DIV clk cycles
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned  W    = presc_width(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] presc_q;
    logic [W-1:0] presc_d;

    // With CLK_DIV = 1 LAST is 0, so the compare is always true and the
    // tick fires every clk.
    assign tick_o = (presc_q == LAST);

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here a single unconditional assignment) so no latch is inferred.
    always_comb begin
        presc_d = tick_o ? '0 : presc_q + W'(1);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their inputs at the same edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral driven by five SPI-written configuration bytes.
// One shared 8-bit, 255-step waveform; each pin is forced low, forced high or
// follows the waveform. The requested duty is shadowed at the period boundary
// so a pin never sees a runt pulse; enable/select changes apply next clk.
// Ports:
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   en_reg_out_7_0    in   output enable, pins 7:0
//   en_reg_out_15_8   in   output enable, pins 15:8
//   en_reg_pwm_7_0    in   PWM select, pins 7:0
//   en_reg_pwm_15_8   in   PWM select, pins 15:8
//   pwm_duty_cycle    in   requested duty (0x00 = 0 %, 0xFF = 100 %)
//   out               out  registered pin drive
//   pwm_period_start  out  one-clk pulse while the PWM counter is at 0
//                          after a wrap
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [DUTY_W-1:0]   pwm_duty_cycle,
    output logic [NUM_PINS-1:0] out,
    output logic                pwm_period_start
);

    logic                tick;
    logic                wrap;
    logic                pwm_sig;
    logic [NUM_PINS-1:0] en_out;
    logic [NUM_PINS-1:0] en_pwm;

    logic [DUTY_W-1:0]   cnt_q,    cnt_d;
    logic [DUTY_W-1:0]   shadow_q, shadow_d;
    logic [NUM_PINS-1:0] out_q,    out_d;
    logic                start_q,  start_d;

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Last tick of the period: the counter returns to 0 and the new duty is
    // captured together, so the waveform and the start pulse stay aligned.
    assign wrap = tick && (cnt_q == PWM_CNT_MAX);

    // Counter tops out at 254, so a shadow of 0xFF is high all period.
    assign pwm_sig = (cnt_q < shadow_q);

    always_comb begin
        cnt_d = cnt_q;
        if (wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + DUTY_W'(1);
        end
    end

    always_comb begin
        shadow_d = wrap ? pwm_duty_cycle : shadow_q;
        start_d  = wrap;
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            case (pin_mode(en_out[i], en_pwm[i]))
                PIN_HIGH: out_d[i] = 1'b1;
                PIN_PWM:  out_d[i] = pwm_sig;
                default:  out_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            start_q  <= start_d;
        end
    end

    assign out              = out_q;
    assign pwm_period_start = start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral with CLK_DIV = 2.
// A time-based reference model (clk count since reset -> counter value,
// period index and latched duty) is compared against the DUT on every falling
// edge; directed scenarios additionally measure high times and edges.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 255 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        pwm_period_start;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_peripheral #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_reg_out_7_0   (en_reg_out_7_0),
        .en_reg_out_15_8  (en_reg_out_15_8),
        .en_reg_pwm_7_0   (en_reg_pwm_7_0),
        .en_reg_pwm_15_8  (en_reg_pwm_15_8),
        .pwm_duty_cycle   (pwm_duty_cycle),
        .out              (out),
        .pwm_period_start (pwm_period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: t counts clk edges since reset release. Counter value
    // is (t / CLK_DIV) % 255; the duty latched at the edge that ends a period
    // is in force for the whole next period.
    int          m_t;
    logic [7:0]  m_shadow;
    logic [15:0] m_out;
    logic        m_ps;

    always @(posedge clk or negedge rst_n) begin
        int   cnt;
        logic sig;
        logic [15:0] eo, ep;
        if (!rst_n) begin
            m_t      = 0;
            m_shadow = 8'h00;
            m_out    = 16'h0000;
            m_ps     = 1'b0;
        end else begin
            cnt   = (m_t / CLK_DIV) % 255;
            sig   = (cnt < int'(m_shadow));
            eo    = {en_reg_out_15_8, en_reg_out_7_0};
            ep    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
            m_out = eo & (~ep | {16{sig}});
            if ((m_t + 1) % PERIOD == 0) begin
                m_shadow = pwm_duty_cycle;
                m_ps     = 1'b1;
            end else begin
                m_ps = 1'b0;
            end
            m_t++;
        end
    end

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_out", 32'(out), 32'(m_out));
            check("mon_ps", 32'(pwm_period_start), 32'(m_ps));
        end
    end

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    // Waits (bounded) for the falling edge at which pwm_period_start is seen
    // high; reports how many falling edges elapsed and how many had out[0] set.
    task automatic wait_ps(output int waited, output int highs, output bit found);
        waited = 0;
        highs  = 0;
        found  = 1'b0;
        while (!found && waited < 4 * PERIOD) begin
            @(negedge clk);
            waited++;
            if (out[0]) highs++;
            if (pwm_period_start) found = 1'b1;
        end
        check("ps_timeout", 32'(found), 32'd1);
    endtask

    // Samples out on n falling edges, starting at the current one (the edge
    // where the period start pulse was seen). Optionally rewrites the duty
    // just after sample sw_at.
    task automatic measure(input int n, input int sw_at, input logic [7:0] sw_duty,
                           output int hi_total, output int hi_first, output int edges,
                           output int first_rise, output logic [15:0] others);
        logic prev;
        hi_total   = 0;
        hi_first   = 0;
        edges      = 0;
        first_rise = -1;
        others     = 16'h0000;
        prev       = out[0];
        for (int s = 0; s < n; s++) begin
            if (s > 0) @(negedge clk);
            if (out[0]) begin
                hi_total++;
                if (s < PERIOD) hi_first++;
            end
            if (out[0] && !prev) begin
                edges++;
                if (first_rise < 0) first_rise = s;
            end
            prev   = out[0];
            others = others | {out[15:1], 1'b0};
            if (s == sw_at) begin
                #1 pwm_duty_cycle = sw_duty;
            end
        end
    endtask

    initial begin
        int waited, highs, hi_t, hi_f, edges, rise;
        bit found;
        logic [15:0] others;

        // Reset with every configuration input at 0xFF.
        rst_n = 1'b0;
        set_en(16'hFFFF, 16'hFFFF);
        pwm_duty_cycle = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_ps", 32'(pwm_period_start), 32'h0);
        mon_en = 1'b1;
        #1 rst_n = 1'b1;

        // First boundary is a full period after release; shadow is 0 until then.
        wait_ps(waited, highs, found);
        check("first_ps_delay", 32'(waited), 32'(PERIOD));
        check("first_period_low", 32'(highs), 32'd0);

        // Static enables.
        #1 set_en(16'hFFFF, 16'h0000);
        @(negedge clk);
        check("static_ffff", 32'(out), 32'hFFFF);
        #1 set_en(16'h00F0, 16'h0000);
        @(negedge clk);
        check("static_00f0", 32'(out), 32'h00F0);

        // Duty 0x80 on pin 0.
        #1 set_en(16'h0001, 16'h0001);
        pwm_duty_cycle = 8'h80;
        wait_ps(waited, highs, found);
        wait_ps(waited, highs, found);
        measure(PERIOD, -1, 8'h00, hi_t, hi_f, edges, rise, others);
        check("d80_high", 32'(hi_t), 32'(128 * CLK_DIV));
        check("d80_low", 32'(PERIOD - hi_t), 32'(PERIOD - 128 * CLK_DIV));
        check("d80_rise_after_ps", 32'(rise), 32'd1);
        check("d80_edges", 32'(edges), 32'd1);
        check("d80_others", 32'(others), 32'h0);

        // Duty 0x00: never high over three periods.
        #1 pwm_duty_cycle = 8'h00;
        wait_ps(waited, highs, found);
        wait_ps(waited, highs, found);
        measure(3 * PERIOD, -1, 8'h00, hi_t, hi_f, edges, rise, others);
        check("d00_high", 32'(hi_t), 32'd0);

        // Duty 0xFF: always high over three periods.
        #1 pwm_duty_cycle = 8'hFF;
        wait_ps(waited, highs, found);
        wait_ps(waited, highs, found);
        measure(3 * PERIOD, -1, 8'h00, hi_t, hi_f, edges, rise, others);
        check("dff_high", 32'(hi_t), 32'(3 * PERIOD));
        check("dff_edges", 32'(edges), 32'd0);

        // Duty 0x40, switched to 0xC0 at counter value 10.
        #1 pwm_duty_cycle = 8'h40;
        wait_ps(waited, highs, found);
        wait_ps(waited, highs, found);
        measure(2 * PERIOD, 10 * CLK_DIV, 8'hC0, hi_t, hi_f, edges, rise, others);
        check("sw_first_high", 32'(hi_f), 32'(64 * CLK_DIV));
        check("sw_second_high", 32'(hi_t - hi_f), 32'(192 * CLK_DIV));
        check("sw_edges", 32'(edges), 32'd2);

        // Reset at counter value 100, held 3 clk.
        wait_ps(waited, highs, found);
        repeat (100 * CLK_DIV) @(negedge clk);
        check("pre_rst_high", 32'(out[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(out), 32'h0);
        check("mid_rst_ps", 32'(pwm_period_start), 32'h0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_ps(waited, highs, found);
        check("post_rst_ps_delay", 32'(waited), 32'(PERIOD));
        check("post_rst_shadow_zero", 32'(highs), 32'd0);

        // Randomised enables and duty, checked by the reference model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) begin
                set_en(16'($urandom), 16'($urandom));
            end
            if ($urandom_range(0, 63) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pwm_duty_cycle = 8'h00;
                    1:       pwm_duty_cycle = 8'hFF;
                    default: pwm_duty_cycle = 8'($urandom);
                endcase
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration bytes written over SPI and drives 16 output pins.
- Each pin is independently forced low, forced high, or driven by one shared PWM waveform.
- The shared waveform is 8-bit duty, 255 steps, about 3 kHz, with a clock prescaler.
- Duty changes are double-buffered and take effect only at a period boundary, so no pin ever sees a runt pulse.

Parameters:
- CLK_DIV, 13, clk cycles per PWM tick (10 MHz / (13*255) ≈ 3.02 kHz); legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en_reg_out_7_0  in  8  output enable, pins 7:0
- en_reg_out_15_8  in  8  output enable, pins 15:8
- en_reg_pwm_7_0  in  8  PWM select, pins 7:0
- en_reg_pwm_15_8  in  8  PWM select, pins 15:8
- pwm_duty_cycle  in  8  requested duty (0x00 = 0 %, 0xFF = 100 %)
- out  out  16  pin drive; out[15:8] from the *_15_8 registers, out[7:0] from the *_7_0 registers
- pwm_period_start  out  1  one-clk pulse on the cycle the PWM counter wraps to 0

Behaviour:
- Reset (rst_n low, async):
  - prescaler, pwm_cnt and duty_shadow = 0
  - out = 16'h0000
  - pwm_period_start = 0
- Prescaler:
  - Counts 0..CLK_DIV-1; tick = (presc == CLK_DIV-1); wraps to 0 on tick.
  - CLK_DIV = 1 gives a tick every clk.
- PWM counter (8 bit):
  - On tick, pwm_cnt increments 0..254 then wraps to 0. The value 255 is never reached.
  - Period = 255*CLK_DIV clk.
- Duty shadow:
  - duty_shadow <= pwm_duty_cycle on the clk where tick && pwm_cnt == 254.
  - In that same cycle pwm_period_start is registered high, so it is high for exactly one clk, aligned with pwm_cnt == 0.
  - Changes to pwm_duty_cycle mid-period are ignored until that boundary.
  - After reset, duty_shadow = 0 for the whole first period.
- Waveform:
  - pwm_sig = (pwm_cnt < duty_shadow).
  - Duty 0x00 gives constant low.
  - Duty 0xFF gives constant high, because pwm_cnt is at most 254.
  - Duty D gives a high time of D*CLK_DIV clk per period.
- Per pin i (registered, latency 1 clk from input/state to out):
  - en_out[i] = 0 → out[i] = 0
  - en_out[i] = 1, en_pwm[i] = 0 → out[i] = 1
  - en_out[i] = 1, en_pwm[i] = 1 → out[i] = pwm_sig
- Enable/select changes apply on the next clk without waiting for a boundary. These inputs are already synchronous to clk and are not resynchronised here.
- All PWM pins are phase-aligned: every one rises at pwm_cnt == 0 when D > 0.
- Reset mid-period: everything returns to reset values immediately. Counting restarts from 0 on the first clk with rst_n high.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_MAX = 8'd254
  - DUTY_W = 8
  - NUM_PINS = 16
  - CLK_DIV_DEFAULT = 13
- Sub-module pwm_tick_gen: parameterised prescaler, outputs the one-cycle tick. Width = $clog2(CLK_DIV), minimum 1.
- Counter, shadow and pin mux stay in pwm_peripheral.

Test Plan:
- Reset with all inputs 0xFF, rst_n held low → out = 0x0000 and pwm_period_start = 0. Release reset → first pwm_period_start occurs 255*CLK_DIV clk later.
- CLK_DIV = 2; en_out = 0xFFFF, en_pwm = 0x0000 → out = 0xFFFF one clk later. Set en_out = 0x00F0 → out = 0x00F0 one clk later.
- CLK_DIV = 2; en_out = en_pwm = 0x0001, duty 0x80:
  - after the first boundary, out[0] is high 256 clk and low 254 clk per 510-clk period
  - the rising edge is 1 clk after pwm_period_start
  - the other pins stay 0
- Duty 0x00 → out[0] is never high across 3 periods. Duty 0xFF → out[0] is constantly high across 3 periods.
- Duty 0x40, then switch to 0xC0 at pwm_cnt = 10 → current period keeps 64-tick high time; next period has 192-tick high time. No extra edges.
- Assert rst_n low at pwm_cnt = 100 for 3 clk → out = 0 immediately. After release, pwm_cnt restarts at 0 and duty_shadow = 0 until the next boundary.
